rf_write_arbiter: RTL and testbench



---
 rtl/rf_arb_pkg.sv | 16 +
 rtl/rf_arb_fifo.sv | 94 +++++++++
 rtl/rf_write_arbiter.sv | 167 ++++++++++++++++
 tb/tb_rf_write_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_arb_pkg.sv
// rtl/rf_arb_pkg.sv - shared widths, queue entry type and requester indices for the RF write arbiter
package rf_arb_pkg;

    localparam int RF_AW = 5;
    localparam int RF_DW = 32;

    // Requester indices; also the encoding of the last_grant register.
    localparam logic REQ_ALU = 1'b0;
    localparam logic REQ_MEM = 1'b1;

    typedef struct packed {
        logic [RF_AW-1:0] addr;
        logic [RF_DW-1:0] data;
    } rf_entry_t;

endpackage

// File: rtl/rf_arb_fifo.sv
// rtl/rf_arb_fifo.sv - in-order {addr,data} queue feeding one side of the RF write arbiter
//   clk, rst                         clock, synchronous active-high reset (empties the queue)
//   push, push_addr, push_data       enqueue (ignored when full)
//   pop                              dequeue head (ignored when empty)
//   full, empty, count               occupancy
//   head_addr, head_data             oldest entry
//   fwd_addr, fwd_hit, fwd_data      youngest-match lookup, only with RF_WRITE_ARB_FWD_EN
module rf_arb_fifo
    import rf_arb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = RF_AW,
    parameter int DW    = RF_DW,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [AW-1:0] push_addr,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic [AW-1:0] head_addr,
`ifdef RF_WRITE_ARB_FWD_EN
    input  logic [AW-1:0] fwd_addr,
    output logic          fwd_hit,
    output logic [DW-1:0] fwd_data,
`endif
    output logic [DW-1:0] head_data
);

    logic [AW-1:0] mem_addr [DEPTH];
    logic [DW-1:0] mem_data [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign push_ok   = push && !full;
    assign pop_ok    = pop && !empty;
    assign head_addr = mem_addr[rd_ptr];
    assign head_data = mem_data[rd_ptr];

    // Storage is not reset: only the count decides which slots are live.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_addr[wr_ptr] <= push_addr;
            mem_data[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointer wrap is plain overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef RF_WRITE_ARB_FWD_EN
    logic [PW-1:0] scan_idx;

    // Walk oldest to youngest; a later match overrides, leaving the youngest.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        scan_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = rd_ptr + PW'(k);
            if ((CW'(k) < count) && (mem_addr[scan_idx] == fwd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = mem_data[scan_idx];
            end
        end
    end
`else
    // No lookup path in this build.
`endif

endmodule

// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - round-robin merge of ALU and load writebacks onto one register-file write port
//   clk, rst                            clock, synchronous active-high reset
//   req0_valid/ready/addr/data          ALU writeback request
//   req1_valid/ready/addr/data          load writeback request
//   wr_en, wr_addr, wr_data             registered register-file write port
//   err_same_dst                        sticky: both queue heads target the same register
//   idle                                both queues empty and no write in flight
//   fwd_addr, fwd_hit, fwd_data         pending-write lookup, only with RF_WRITE_ARB_FWD_EN
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = RF_AW,
    parameter int DW    = RF_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_data,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_data,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          err_same_dst,
`ifdef RF_WRITE_ARB_FWD_EN
    input  logic [AW-1:0] fwd_addr,
    output logic          fwd_hit,
    output logic [DW-1:0] fwd_data,
`endif
    output logic          idle
);

    localparam int CW = $clog2(DEPTH + 1);

    logic          full0, full1, empty0, empty1;
    logic [CW-1:0] count0, count1;
    logic [AW-1:0] head0_addr, head1_addr;
    logic [DW-1:0] head0_data, head1_data;
    logic          push0, push1;
    logic          grant0, grant1;
    logic          last_grant;
    logic          same_dst;

    // Ready comes from pre-edge occupancy only, so a full queue stays
    // not-ready even while it is being popped.
    assign req0_ready = !full0 && !rst;
    assign req1_ready = !full1 && !rst;

    // Writes to r0 are accepted but dropped at the door.
    assign push0 = req0_valid && req0_ready && (req0_addr != '0);
    assign push1 = req1_valid && req1_ready && (req1_addr != '0);

`ifdef RF_WRITE_ARB_FWD_EN
    logic          q0_hit, q1_hit;
    logic [DW-1:0] q0_data, q1_data;
`endif

    rf_arb_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_alu_q (
        .clk       (clk),
        .rst       (rst),
        .push      (push0),
        .push_addr (req0_addr),
        .push_data (req0_data),
        .pop       (grant0),
        .full      (full0),
        .empty     (empty0),
        .count     (count0),
        .head_addr (head0_addr),
`ifdef RF_WRITE_ARB_FWD_EN
        .fwd_addr  (fwd_addr),
        .fwd_hit   (q0_hit),
        .fwd_data  (q0_data),
`endif
        .head_data (head0_data)
    );

    rf_arb_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_mem_q (
        .clk       (clk),
        .rst       (rst),
        .push      (push1),
        .push_addr (req1_addr),
        .push_data (req1_data),
        .pop       (grant1),
        .full      (full1),
        .empty     (empty1),
        .count     (count1),
        .head_addr (head1_addr),
`ifdef RF_WRITE_ARB_FWD_EN
        .fwd_addr  (fwd_addr),
        .fwd_hit   (q1_hit),
        .fwd_data  (q1_data),
`endif
        .head_data (head1_data)
    );

    // Under contention the requester that did not win last time goes first.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!empty0 && !empty1) begin
            if (last_grant == REQ_MEM) grant0 = 1'b1;
            else                       grant1 = 1'b1;
        end else if (!empty0) begin
            grant0 = 1'b1;
        end else if (!empty1) begin
            grant1 = 1'b1;
        end
    end

    assign same_dst = !empty0 && !empty1 && (head0_addr == head1_addr) && (head0_addr != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            err_same_dst <= 1'b0;
            last_grant   <= REQ_MEM;
        end else begin
            if (grant0) begin
                wr_en      <= 1'b1;
                wr_addr    <= head0_addr;
                wr_data    <= head0_data;
                last_grant <= REQ_ALU;
            end else if (grant1) begin
                wr_en      <= 1'b1;
                wr_addr    <= head1_addr;
                wr_data    <= head1_data;
                last_grant <= REQ_MEM;
            end else begin
                wr_en <= 1'b0;
            end
            if (same_dst) err_same_dst <= 1'b1;
        end
    end

    assign idle = (count0 == '0) && (count1 == '0) && !wr_en;

`ifdef RF_WRITE_ARB_FWD_EN
    // Queued entries are newer than the one in the output register.
    // A stale wr_addr with wr_en low is already in the register file.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (fwd_addr != '0) begin
            if (q0_hit) begin
                fwd_hit  = 1'b1;
                fwd_data = q0_data;
            end else if (q1_hit) begin
                fwd_hit  = 1'b1;
                fwd_data = q1_data;
            end else if (wr_en && (wr_addr == fwd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = wr_data;
            end
        end
    end
`else
    // Forwarding lookup not built.
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - directed self-checking bench for rf_write_arbiter (DEPTH=2)
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [4:0]  req0_addr, req1_addr;
    logic [31:0] req0_data, req1_data;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        err_same_dst;
    logic        idle;
`ifdef RF_WRITE_ARB_FWD_EN
    logic [4:0]  fwd_addr;
    logic        fwd_hit;
    logic [31:0] fwd_data;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rf_write_arbiter #(.DEPTH(2), .AW(5), .DW(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_addr    (req0_addr),
        .req0_data    (req0_data),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_addr    (req1_addr),
        .req1_data    (req1_data),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .err_same_dst (err_same_dst),
`ifdef RF_WRITE_ARB_FWD_EN
        .fwd_addr     (fwd_addr),
        .fwd_hit      (fwd_hit),
        .fwd_data     (fwd_data),
`endif
        .idle         (idle)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    endtask

    task automatic drive0(input logic [4:0] a, input logic [31:0] d);
        req0_valid = 1'b1; req0_addr = a; req0_data = d;
    endtask

    task automatic drive1(input logic [4:0] a, input logic [31:0] d);
        req1_valid = 1'b1; req1_addr = a; req1_data = d;
    endtask

    task automatic pulse_reset();
        quiet();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic expect_write(input string tag, input logic [4:0] a, input logic [31:0] d);
        check({tag, ".wr_en"}, 32'(wr_en), 32'd1);
        check({tag, ".wr_addr"}, 32'(wr_addr), 32'(a));
        check({tag, ".wr_data"}, wr_data, d);
    endtask

    initial begin
        quiet();
`ifdef RF_WRITE_ARB_FWD_EN
        fwd_addr = '0;
`endif
        rst = 1'b1;
        tick();
        tick();
        check("rst.wr_en", 32'(wr_en), 32'd0);
        check("rst.wr_addr", 32'(wr_addr), 32'd0);
        check("rst.wr_data", wr_data, 32'd0);
        check("rst.err", 32'(err_same_dst), 32'd0);
        check("rst.ready0", 32'(req0_ready), 32'd0);
        check("rst.ready1", 32'(req1_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("rel.ready0", 32'(req0_ready), 32'd1);
        check("rel.ready1", 32'(req1_ready), 32'd1);
        check("rel.idle", 32'(idle), 32'd1);

        // Single ALU write, one cycle latency
        drive0(5'd5, 32'hDEADBEEF);
        tick();
        quiet();
        check("single.accept.wr_en", 32'(wr_en), 32'd0);
        check("single.accept.idle", 32'(idle), 32'd0);
        tick();
        expect_write("single", 5'd5, 32'hDEADBEEF);
        tick();
        check("single.after.wr_en", 32'(wr_en), 32'd0);
        check("single.after.idle", 32'(idle), 32'd1);
        check("single.hold.wr_addr", 32'(wr_addr), 32'd5);

        // Simultaneous: req0 wins first contention after reset
        pulse_reset();
        drive0(5'd3, 32'h11);
        drive1(5'd4, 32'h22);
        tick();
        quiet();
        tick();
        expect_write("simul.first", 5'd3, 32'h11);
        tick();
        expect_write("simul.second", 5'd4, 32'h22);
        tick();
        check("simul.done.wr_en", 32'(wr_en), 32'd0);
        check("simul.done.idle", 32'(idle), 32'd1);

        // Backpressure on req1 with DEPTH=2
        pulse_reset();
        drive0(5'd10, 32'hA0);
        drive1(5'd20, 32'hB0);
        tick();
        check("bp.e1.wr_en", 32'(wr_en), 32'd0);
        drive0(5'd11, 32'hA1);
        drive1(5'd21, 32'hB1);
        tick();
        expect_write("bp.e2", 5'd10, 32'hA0);
        check("bp.e2.ready1", 32'(req1_ready), 32'd0);
        check("bp.e2.ready0", 32'(req0_ready), 32'd1);
        req0_valid = 1'b0;
        drive1(5'd22, 32'hB2);
        tick();
        expect_write("bp.e3", 5'd20, 32'hB0);
        check("bp.e3.ready1", 32'(req1_ready), 32'd1);
        tick();
        expect_write("bp.e4", 5'd11, 32'hA1);
        check("bp.e4.ready1", 32'(req1_ready), 32'd0);
        quiet();
        tick();
        expect_write("bp.e5", 5'd21, 32'hB1);
        tick();
        expect_write("bp.e6", 5'd22, 32'hB2);
        tick();
        check("bp.e7.wr_en", 32'(wr_en), 32'd0);
        check("bp.e7.idle", 32'(idle), 32'd1);

        // Zero register writes are swallowed
        drive0(5'd0, 32'h55);
        check("zero.ready0", 32'(req0_ready), 32'd1);
        tick();
        quiet();
        check("zero.e1.wr_en", 32'(wr_en), 32'd0);
        check("zero.e1.idle", 32'(idle), 32'd1);
        tick();
        check("zero.e2.wr_en", 32'(wr_en), 32'd0);
        check("zero.e2.idle", 32'(idle), 32'd1);

`ifdef RF_WRITE_ARB_FWD_EN
        // Forwarding from queue, output register, youngest queue entry
        pulse_reset();
        fwd_addr = 5'd9;
        drive0(5'd5, 32'h50);
        drive1(5'd9, 32'hAB);
        tick();
        quiet();
        #1;
        check("fwd.q.hit", 32'(fwd_hit), 32'd1);
        check("fwd.q.data", fwd_data, 32'hAB);
        tick();
        check("fwd.q2.hit", 32'(fwd_hit), 32'd1);
        check("fwd.q2.data", fwd_data, 32'hAB);
        fwd_addr = 5'd5;
        #1;
        check("fwd.out.hit", 32'(fwd_hit), 32'd1);
        check("fwd.out.data", fwd_data, 32'h50);
        fwd_addr = 5'd9;
        tick();
        check("fwd.out9.hit", 32'(fwd_hit), 32'd1);
        check("fwd.out9.data", fwd_data, 32'hAB);
        tick();
        check("fwd.gone.hit", 32'(fwd_hit), 32'd0);
        fwd_addr = 5'd0;
        #1;
        check("fwd.zero.hit", 32'(fwd_hit), 32'd0);
        fwd_addr = 5'd9;
        drive1(5'd9, 32'hC1);
        tick();
        drive1(5'd9, 32'hC2);
        tick();
        quiet();
        #1;
        check("fwd.young.hit", 32'(fwd_hit), 32'd1);
        check("fwd.young.data", fwd_data, 32'hC2);
        tick();
        tick();
        fwd_addr = 5'd0;
`endif

        // Same-destination contract violation, sticky
        drive0(5'd7, 32'h70);
        drive1(5'd7, 32'h71);
        tick();
        quiet();
        check("viol.e1.err", 32'(err_same_dst), 32'd0);
        tick();
        check("viol.e2.err", 32'(err_same_dst), 32'd1);
        expect_write("viol.e2", 5'd7, 32'h70);
        tick();
        check("viol.e3.err", 32'(err_same_dst), 32'd1);
        expect_write("viol.e3", 5'd7, 32'h71);
        tick();
        check("viol.e4.err", 32'(err_same_dst), 32'd1);

        // Reset mid-drain drops pending entries
        drive0(5'd1, 32'h101);
        drive1(5'd2, 32'h202);
        tick();
        drive0(5'd3, 32'h303);
        drive1(5'd4, 32'h404);
        tick();
        expect_write("mid.e2", 5'd1, 32'h101);
        quiet();
        rst = 1'b1;
        tick();
        check("mid.rst.wr_en", 32'(wr_en), 32'd0);
        check("mid.rst.wr_addr", 32'(wr_addr), 32'd0);
        check("mid.rst.wr_data", wr_data, 32'd0);
        check("mid.rst.err", 32'(err_same_dst), 32'd0);
        check("mid.rst.ready0", 32'(req0_ready), 32'd0);
        check("mid.rst.ready1", 32'(req1_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("mid.rel.ready0", 32'(req0_ready), 32'd1);
        check("mid.rel.ready1", 32'(req1_ready), 32'd1);
        check("mid.rel.idle", 32'(idle), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mid.drain.wr_en", 32'(wr_en), 32'd0);
        end
        check("mid.final.idle", 32'(idle), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
